// File: rtl/sim_link_ctrl_if.sv
// Byte link between the simulator-link controller and the UART (tx + rx side).
// Latency: wires only; no storage in the interface.
// Backpressure: tx byte is held while tx_valid && !tx_ready; rx is a 1-cycle strobe with no backpressure.
//
// Signals:
//   tx_data/tx_valid : controller -> UART transmitter
//   tx_ready         : UART transmitter -> controller
//   rx_data/rx_valid : UART receiver -> controller
interface sim_link_ctrl_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    // master: the link controller
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    // slave: the UART side
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/sim_link_ctrl.sv
// Mode arbiter + simulator-link controller: picks a driver channel, frames moving commands to the UART, debounces detector bytes.
// Latency: selection 1 cycle; first tx_valid 1 cycle after moving_state changes; detector updates the cycle after the qualifying rx byte.
// Backpressure: a framed byte is held unchanged while tx_ready=0; newer commands wait for the next frame; rx has no backpressure.
//
// Ports:
//   sys_clk, rst (async active-low)
//   power, global_state, mode_state, mode_moving, mode_pl_beacon, mode_de_beacon : driver channel inputs
//   link (sim_link_ctrl_if.master) : tx byte handshake + rx byte strobe
//   detector, link_ok              : debounced detector bits and link supervision
//   state, moving_state            : registered selected channel
//   state_light, moving_light      : indicator lights
module sim_link_ctrl #(
    parameter int  NUM_MODES      = 4,
    parameter int  DET_WIDTH      = 4,
    parameter int  DEBOUNCE_CNT   = 3,
    parameter int  REFRESH_CYCLES = 100000,
    parameter int  TIMEOUT_CYCLES = 1000000,
    localparam int MODE_W         = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
    input  logic                   sys_clk,
    input  logic                   rst,
    input  logic                   power,
    input  logic [MODE_W-1:0]      global_state,
    input  logic [2*NUM_MODES-1:0] mode_state,
    input  logic [4*NUM_MODES-1:0] mode_moving,
    input  logic [NUM_MODES-1:0]   mode_pl_beacon,
    input  logic [NUM_MODES-1:0]   mode_de_beacon,
    sim_link_ctrl_if.master        link,
    output logic [DET_WIDTH-1:0]   detector,
    output logic                   link_ok,
    output logic [1:0]             state,
    output logic [3:0]             moving_state,
    output logic [2:0]             state_light,
    output logic [3:0]             moving_light
);

    localparam int RC_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MC_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [RC_W-1:0] REFRESH_LAST = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_MAX       = TO_W'(TIMEOUT_CYCLES);
    localparam logic [MC_W-1:0] MC_MAX       = MC_W'(DEBOUNCE_CNT);
    localparam logic [MODE_W:0] MODES_V      = (MODE_W+1)'(NUM_MODES);

    // ------------------------------------------------------------------
    // Channel selection
    // ------------------------------------------------------------------
    logic [1:0]        sel_state;
    logic [3:0]        sel_moving;
    logic              sel_pl;
    logic              sel_de;
    logic              sel_ok;
    logic [MODE_W-1:0] gs_q;
    logic              lit_on;
    logic              lit_mode0;

    // An out-of-range channel number behaves exactly like power off.
    assign sel_ok = power && ({1'b0, global_state} < MODES_V);

    always_comb begin
        sel_state  = '0;
        sel_moving = '0;
        sel_pl     = 1'b0;
        sel_de     = 1'b0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (global_state == MODE_W'(k)) begin
                sel_state  = mode_state[2*k +: 2];
                sel_moving = mode_moving[4*k +: 4];
                sel_pl     = mode_pl_beacon[k];
                sel_de     = mode_de_beacon[k];
            end
        end
    end

    // gs_q remembers last cycle's channel so a switch produces one zero
    // cycle before the new channel's values are registered.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state        <= '0;
            moving_state <= '0;
            gs_q         <= '0;
            lit_on       <= 1'b0;
            lit_mode0    <= 1'b0;
        end else begin
            gs_q      <= global_state;
            lit_on    <= sel_ok;
            lit_mode0 <= (global_state == '0);
            if (sel_ok && (global_state == gs_q)) begin
                state        <= sel_state;
                moving_state <= sel_moving;
            end else begin
                state        <= '0;
                moving_state <= '0;
            end
        end
    end

    // Lights follow the registers; lit_on/lit_mode0 are registered together
    // with state so the indicator never mixes old state with new mode/power.
    always_comb begin
        state_light = 3'b000;
        if (lit_on) begin
            case (state)
                2'd0:    state_light = 3'b001;
                2'd1:    state_light = 3'b010;
                2'd2:    state_light = 3'b100;
                default: state_light = lit_mode0 ? 3'b100 : 3'b111;
            endcase
        end
    end

    assign moving_light = moving_state;

    // ------------------------------------------------------------------
    // TX framing FSM
    // ------------------------------------------------------------------
    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_st_t;

    tx_st_t            tx_st;
    tx_st_t            tx_st_nxt;
    logic [7:0]        frame;
    logic [3:0]        last_sent;
    logic [RC_W-1:0]   refresh_cnt;
    logic              pl_pend;
    logic              de_pend;
    logic              send_req;
    logic              tx_hs;

    assign send_req = (moving_state != last_sent) || pl_pend || de_pend ||
                      (refresh_cnt == REFRESH_LAST);
    assign tx_hs    = (tx_st == TX_SEND) && link.tx_ready;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tx_st <= TX_IDLE;
        end else begin
            tx_st <= tx_st_nxt;
        end
    end

    always_comb begin
        tx_st_nxt = tx_st;
        case (tx_st)
            TX_IDLE: if (send_req)      tx_st_nxt = TX_SEND;
            TX_SEND: if (link.tx_ready) tx_st_nxt = TX_IDLE;
            default:                    tx_st_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        link.tx_valid = (tx_st == TX_SEND);
        link.tx_data  = frame;
    end

    // The frame is snapshotted on IDLE->SEND and never touched while held,
    // so a command change mid-handshake simply re-triggers the next frame.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            frame       <= '0;
            last_sent   <= '0;
            refresh_cnt <= '0;
            pl_pend     <= 1'b0;
            de_pend     <= 1'b0;
        end else begin
            if ((tx_st == TX_IDLE) && (tx_st_nxt == TX_SEND)) begin
                frame <= {2'b10, de_pend, pl_pend, moving_state};
            end
            if (tx_hs) begin
                last_sent   <= frame[3:0];
                refresh_cnt <= '0;
            end else if ((tx_st == TX_IDLE) && (refresh_cnt != REFRESH_LAST)) begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            // Clear only what the accepted frame actually carried; a pulse in
            // the handshake cycle itself survives for the next frame.
            pl_pend <= (pl_pend && !(tx_hs && frame[4])) || (sel_ok && sel_pl);
            de_pend <= (de_pend && !(tx_hs && frame[5])) || (sel_ok && sel_de);
        end
    end

    // ------------------------------------------------------------------
    // Detector debounce and link supervision
    // ------------------------------------------------------------------
    logic [DET_WIDTH-1:0] rx_bits;
    logic [DET_WIDTH-1:0] cand;
    logic [DET_WIDTH-1:0] det_q;
    logic [MC_W-1:0]      match_cnt;
    logic [TO_W-1:0]      to_cnt;
    logic                 seen;
    logic [DET_WIDTH-1:0] base_cand;
    logic [DET_WIDTH-1:0] base_det;
    logic [MC_W-1:0]      base_match;
    logic [DET_WIDTH-1:0] cand_nxt;
    logic [DET_WIDTH-1:0] det_nxt;
    logic [MC_W-1:0]      match_nxt;
    logic                 unused_rx_hi;

    assign rx_bits      = link.rx_data[DET_WIDTH-1:0];
    assign unused_rx_hi = ^link.rx_data[7:DET_WIDTH];

    assign link_ok  = seen && (to_cnt < TO_MAX);
    // Gated at the output too, so detector reads 0 in the very cycle the
    // link drops rather than one cycle later when the registers clear.
    assign detector = link_ok ? det_q : '0;

    // While the link is down the debounce state is treated as cleared; a byte
    // arriving in that cycle starts a fresh run instead of being discarded.
    always_comb begin
        base_cand  = link_ok ? cand      : '0;
        base_match = link_ok ? match_cnt : '0;
        base_det   = link_ok ? det_q     : '0;
        cand_nxt   = base_cand;
        match_nxt  = base_match;
        det_nxt    = base_det;
        if (link.rx_valid) begin
            if (rx_bits == base_cand) begin
                if (base_match != MC_MAX) begin
                    match_nxt = base_match + 1'b1;
                end
            end else begin
                cand_nxt  = rx_bits;
                match_nxt = MC_W'(1);
            end
            if (match_nxt == MC_MAX) begin
                det_nxt = cand_nxt;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            cand      <= '0;
            match_cnt <= '0;
            det_q     <= '0;
            to_cnt    <= '0;
            seen      <= 1'b0;
        end else begin
            cand      <= cand_nxt;
            match_cnt <= match_nxt;
            det_q     <= det_nxt;
            if (link.rx_valid) begin
                to_cnt <= '0;
                seen   <= 1'b1;
            end else if (to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sim_link_ctrl.sv
// Randomized + directed bench for sim_link_ctrl against a behavioural model.
// Latency: model advances once per rising edge, outputs sampled on the falling edge.
// Backpressure: tx_ready is driven randomly to exercise held frames.
module tb_sim_link_ctrl;
    localparam int NM = 4;
    localparam int DW = 4;
    localparam int DB = 3;
    localparam int RC = 16;
    localparam int TO = 50;

    logic            sys_clk = 1'b0;
    logic            rst;
    logic            power;
    logic [1:0]      global_state;
    logic [2*NM-1:0] mode_state;
    logic [4*NM-1:0] mode_moving;
    logic [NM-1:0]   mode_pl_beacon;
    logic [NM-1:0]   mode_de_beacon;
    logic [DW-1:0]   detector;
    logic            link_ok;
    logic [1:0]      state;
    logic [3:0]      moving_state;
    logic [2:0]      state_light;
    logic [3:0]      moving_light;

    sim_link_ctrl_if lnk ();

    sim_link_ctrl #(
        .NUM_MODES      (NM),
        .DET_WIDTH      (DW),
        .DEBOUNCE_CNT   (DB),
        .REFRESH_CYCLES (RC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .power          (power),
        .global_state   (global_state),
        .mode_state     (mode_state),
        .mode_moving    (mode_moving),
        .mode_pl_beacon (mode_pl_beacon),
        .mode_de_beacon (mode_de_beacon),
        .link           (lnk),
        .detector       (detector),
        .link_ok        (link_ok),
        .state          (state),
        .moving_state   (moving_state),
        .state_light    (state_light),
        .moving_light   (moving_light)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [1:0] m_state;
    logic [3:0] m_moving;
    bit         m_on, m_mode0;
    logic [1:0] m_prev_gs;
    bit         m_pl, m_de, m_busy;
    logic [7:0] m_byte;
    logic [3:0] m_last;
    int         m_idle;
    int         m_cyc, m_last_rx;
    bit         m_seen;
    logic [3:0] m_det;
    logic [3:0] m_hist[$];

    function automatic void model_reset();
        m_state = '0; m_moving = '0; m_on = 0; m_mode0 = 0; m_prev_gs = '0;
        m_pl = 0; m_de = 0; m_busy = 0; m_byte = '0; m_last = '0; m_idle = 0;
        m_cyc = 0; m_last_rx = 0; m_seen = 0; m_det = '0;
        m_hist.delete();
    endfunction

    function automatic bit m_link();
        return m_seen && ((m_cyc - m_last_rx) < TO);
    endfunction

    function automatic logic [2:0] exp_light(bit on, bit mode0, logic [1:0] s);
        if (!on) return 3'b000;
        if (s == 2'd0) return 3'b001;
        if (s == 2'd1) return 3'b010;
        if (s == 2'd2 || mode0) return 3'b100;
        return 3'b111;
    endfunction

    // One clock edge of the specified behaviour, from the inputs in force.
    function automatic void model_edge();
        int         g;
        bit         sel_ok, up_pre, hs, go, same;
        logic [3:0] bits;
        g      = int'(global_state);
        sel_ok = power && (g < NM);
        up_pre = m_link();

        hs = m_busy && lnk.tx_ready;
        go = !m_busy && ((m_moving != m_last) || m_pl || m_de || (m_idle >= RC - 1));
        if (!m_busy && m_idle < RC - 1) m_idle++;
        if (hs) begin
            m_last = m_byte[3:0];
            m_idle = 0;
            m_busy = 0;
            if (m_byte[4]) m_pl = 0;
            if (m_byte[5]) m_de = 0;
        end else if (go) begin
            m_byte = {2'b10, m_de, m_pl, m_moving};
            m_busy = 1;
        end
        if (sel_ok && mode_pl_beacon[g]) m_pl = 1;
        if (sel_ok && mode_de_beacon[g]) m_de = 1;

        if (sel_ok && global_state == m_prev_gs) begin
            m_state  = mode_state[2*g +: 2];
            m_moving = mode_moving[4*g +: 4];
        end else begin
            m_state  = '0;
            m_moving = '0;
        end
        m_on      = sel_ok;
        m_mode0   = (g == 0);
        m_prev_gs = global_state;

        m_cyc++;
        if (!up_pre) begin
            m_hist.delete();
            m_det = '0;
        end
        if (lnk.rx_valid) begin
            bits      = lnk.rx_data[3:0];
            m_seen    = 1;
            m_last_rx = m_cyc;
            m_hist.push_back(bits);
            if (m_hist.size() > DB) void'(m_hist.pop_front());
            same = (m_hist.size() == DB);
            foreach (m_hist[i]) if (m_hist[i] != bits) same = 0;
            if (same) m_det = bits;
        end
    endfunction

    task automatic compare_all();
        chk("state", state, m_state);
        chk("moving_state", moving_state, m_moving);
        chk("state_light", state_light, exp_light(m_on, m_mode0, m_state));
        chk("moving_light", moving_light, m_moving);
        chk("tx_valid", lnk.tx_valid, m_busy);
        if (m_busy) chk("tx_data", lnk.tx_data, m_byte);
        chk("link_ok", link_ok, m_link());
        chk("detector", detector, m_link() ? m_det : 4'h0);
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
        compare_all();
    endtask

    task automatic rst_checks();
        chk("rst_tx_valid", lnk.tx_valid, 0);
        chk("rst_tx_data", lnk.tx_data, 0);
        chk("rst_state", state, 0);
        chk("rst_moving", moving_state, 0);
        chk("rst_state_light", state_light, 0);
        chk("rst_moving_light", moving_light, 0);
        chk("rst_detector", detector, 0);
        chk("rst_link_ok", link_ok, 0);
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        model_reset();
        rst_checks();
        @(negedge sys_clk);
        compare_all();
        rst = 1'b1;
    endtask

    logic [7:0] t5_bytes [5];
    bit         found;
    int         gap, n_frames;
    logic [3:0] lo;

    initial begin
        rst = 1'b0; power = 1'b0; global_state = '0;
        mode_state = '0; mode_moving = '0; mode_pl_beacon = '0; mode_de_beacon = '0;
        lnk.tx_ready = 1'b0; lnk.rx_data = '0; lnk.rx_valid = 1'b0;
        #3;
        model_reset();
        rst_checks();
        @(negedge sys_clk);
        rst = 1'b1;

        // Mode 1 command reaches the UART one cycle after it is registered.
        power = 1'b1; global_state = 2'd1; lnk.tx_ready = 1'b1;
        mode_state  = 8'b11_11_01_00;                // ch2=3, ch1=1
        mode_moving = 16'h0_4_0_0;                   // ch2=0100, ch1=0000
        repeat (3) step();
        mode_moving[7:4] = 4'b0001;
        step();
        chk("t2_moving", moving_state, 4'b0001);
        step();
        chk("t2_tx_valid", lnk.tx_valid, 1);
        chk("t2_tx_data", lnk.tx_data, 8'b1000_0001);

        // Channel handover 1 -> 2.
        global_state = 2'd2;
        step();
        chk("t3_handover_state", state, 0);
        step();
        chk("t3_state", state, 3);
        chk("t3_light", state_light, 3'b111);
        found = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (lnk.tx_valid && lnk.tx_data == 8'h84) found = 1;
        end
        chk("t3_new_frame", found, 1);

        // Place beacon held under backpressure.
        repeat (3) step();
        lnk.tx_ready = 1'b0;
        mode_pl_beacon[2] = 1'b1;
        step();
        mode_pl_beacon = '0;
        step();
        chk("t4_valid", lnk.tx_valid, 1);
        chk("t4_frame", lnk.tx_data, 8'h94);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_hold", lnk.tx_data, 8'h94);
        end
        lnk.tx_ready = 1'b1;
        step();
        chk("t4_released", lnk.tx_valid, 0);
        mode_moving[11:8] = 4'b0010;
        step();
        step();
        chk("t4_next_valid", lnk.tx_valid, 1);
        chk("t4_next_frame", lnk.tx_data, 8'h82);

        // Debounce: only the third consecutive 0x02 updates the detector.
        t5_bytes = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h02};
        for (int i = 0; i < 5; i++) begin
            lnk.rx_data = t5_bytes[i]; lnk.rx_valid = 1'b1;
            step();
            lnk.rx_valid = 1'b0;
            chk("t5_detector", detector, (i < 4) ? 4'h0 : 4'b0010);
            step();
        end
        chk("t5_link_ok", link_ok, 1);

        // Silence: link timeout and periodic resend of the same byte.
        gap = 0; n_frames = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (lnk.tx_valid) begin
                chk("t6_refresh_byte", lnk.tx_data, 8'h82);
                if (n_frames > 0) chk("t6_refresh_gap", gap, RC);
                n_frames++;
                gap = 0;
            end else begin
                gap++;
            end
        end
        chk("t6_link_ok", link_ok, 0);
        chk("t6_detector", detector, 0);
        chk("t6_refresh_seen", (n_frames >= 3), 1);

        // Reset while a beacon frame is stalled on the line.
        lnk.tx_ready = 1'b0;
        mode_pl_beacon[2] = 1'b1;
        step();
        mode_pl_beacon = '0;
        step();
        chk("t1_valid_before", lnk.tx_valid, 1);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if ($urandom_range(0, 49) == 0) global_state = 2'($urandom_range(0, 3));
            power = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) begin
                mode_state  = 8'($urandom);
                mode_moving = 16'($urandom);
            end
            for (int k = 0; k < NM; k++) begin
                mode_pl_beacon[k] = ($urandom_range(0, 19) == 0);
                mode_de_beacon[k] = ($urandom_range(0, 19) == 0);
            end
            lnk.tx_ready = ($urandom_range(0, 2) != 0);
            if ((i % 300) < 200 && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 2))
                    0:       lo = 4'h3;
                    1:       lo = 4'h5;
                    default: lo = 4'($urandom);
                endcase
                lnk.rx_data  = {4'($urandom), lo};
                lnk.rx_valid = 1'b1;
            end else begin
                lnk.rx_valid = 1'b0;
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
